// File: rtl/cacheline_arbiter.sv
// Shares one burst memory port between the icache (read-only) and dcache (read/write),
// splitting each cacheline into BEATS bursts and reassembling read lines.
module cacheline_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned BURST_WIDTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [ADDR_WIDTH-1:0]  i_addr_i,
  input  logic                   i_read_i,
  output logic [LINE_WIDTH-1:0]  i_rdata_o,
  output logic                   i_resp_o,
  input  logic [ADDR_WIDTH-1:0]  d_addr_i,
  input  logic                   d_read_i,
  input  logic                   d_write_i,
  input  logic [LINE_WIDTH-1:0]  d_wdata_i,
  output logic [LINE_WIDTH-1:0]  d_rdata_o,
  output logic                   d_resp_o,
  output logic [ADDR_WIDTH-1:0]  bmem_addr_o,
  output logic                   bmem_read_o,
  output logic                   bmem_write_o,
  output logic [BURST_WIDTH-1:0] bmem_wdata_o,
  input  logic [BURST_WIDTH-1:0] bmem_rdata_i,
  input  logic                   bmem_resp_i
);

  localparam int unsigned Beats = LINE_WIDTH / BURST_WIDTH;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIRead,
    StDRead,
    StDWrite,
    StDoneI,
    StDoneD
  } state_e;

  state_e                  state_q;
  logic [BeatW-1:0]        beat_q;
  logic                    last_grant_q;  // 0: icache, 1: dcache
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    bmem_read_q;
  logic                    bmem_write_q;
  logic                    i_resp_q;
  logic                    d_resp_q;
  logic [LINE_WIDTH-1:0]   line_q;
  logic [LINE_WIDTH-1:0]   line_d;
  logic [LINE_WIDTH-1:0]   i_rdata_q;
  logic [LINE_WIDTH-1:0]   d_rdata_q;

  logic i_req, d_req, d_wins, last_beat;

  assign i_req     = i_read_i;
  assign d_req     = d_read_i | d_write_i;
  assign d_wins    = d_req & (~i_req | ~last_grant_q);
  assign last_beat = bmem_resp_i && (beat_q == BeatW'(Beats - 1));

  // Staging buffer with the current beat merged in; copied out only on completion
  // so the requester's line stays stable until its next read finishes.
  always_comb begin
    line_d = line_q;
    line_d[beat_q * BURST_WIDTH +: BURST_WIDTH] = bmem_rdata_i;
  end

  always_comb begin
    bmem_wdata_o = '0;
    if (bmem_write_q) begin
      bmem_wdata_o = d_wdata_i[beat_q * BURST_WIDTH +: BURST_WIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      beat_q       <= '0;
      last_grant_q <= 1'b0;
      addr_q       <= '0;
      bmem_read_q  <= 1'b0;
      bmem_write_q <= 1'b0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
      line_q       <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (d_wins) begin
            // Write wins over read if a misbehaving dcache raises both.
            state_q      <= d_write_i ? StDWrite : StDRead;
            last_grant_q <= 1'b1;
            addr_q       <= d_addr_i & AlignMask;
            bmem_read_q  <= ~d_write_i;
            bmem_write_q <= d_write_i;
          end else if (i_req) begin
            state_q      <= StIRead;
            last_grant_q <= 1'b0;
            addr_q       <= i_addr_i & AlignMask;
            bmem_read_q  <= 1'b1;
          end
        end
        StIRead, StDRead: begin
          if (bmem_resp_i) begin
            line_q <= line_d;
            beat_q <= last_beat ? '0 : beat_q + BeatW'(1);
            if (last_beat) begin
              bmem_read_q <= 1'b0;
              if (state_q == StIRead) begin
                i_rdata_q <= line_d;
                i_resp_q  <= 1'b1;
                state_q   <= StDoneI;
              end else begin
                d_rdata_q <= line_d;
                d_resp_q  <= 1'b1;
                state_q   <= StDoneD;
              end
            end
          end
        end
        StDWrite: begin
          if (bmem_resp_i) begin
            beat_q <= last_beat ? '0 : beat_q + BeatW'(1);
            if (last_beat) begin
              bmem_write_q <= 1'b0;
              d_resp_q     <= 1'b1;
              state_q      <= StDoneD;
            end
          end
        end
        StDoneI, StDoneD: state_q <= StIdle;
        default:          state_q <= StIdle;
      endcase
    end
  end

  assign i_rdata_o    = i_rdata_q;
  assign d_rdata_o    = d_rdata_q;
  assign i_resp_o     = i_resp_q;
  assign d_resp_o     = d_resp_q;
  assign bmem_addr_o  = addr_q;
  assign bmem_read_o  = bmem_read_q;
  assign bmem_write_o = bmem_write_q;

endmodule
